// File: rtl/pdcch_dmrs_symbol_controller.sv
// Expands one CORESET/PDCCH configuration into one DMRS config beat per CORESET symbol,
// each carrying c_init, PN length, DMRS offset, symbol index and frequency bitmap.
module pdcch_dmrs_symbol_controller #(
  parameter int SLOT_W       = 7,
  parameter int NID_W        = 16,
  parameter int RB_W         = 9,
  parameter int BITMAP_W     = 45,
  parameter int MAX_DURATION = 3,
  parameter int PN_W         = RB_W + 4,
  localparam int IN_W        = SLOT_W + 4 + 2 + NID_W + 2 * RB_W + 1 + BITMAP_W,
  localparam int OUT_W       = 31 + 2 * PN_W + 4 + BITMAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  s_axis_cont_config_data,
  input  logic             s_axis_cont_config_valid,
  output logic             s_axis_cont_config_ready,
  output logic [OUT_W-1:0] m_axis_cont_config_data,
  output logic             m_axis_cont_config_valid,
  output logic             m_axis_cont_config_last,
  input  logic             m_axis_cont_config_ready,
  output logic             cfg_reject,
  output logic             busy
);

  localparam int OFF_START = SLOT_W;
  localparam int OFF_DUR   = OFF_START + 4;
  localparam int OFF_NID   = OFF_DUR + 2;
  localparam int OFF_SIZE  = OFF_NID + NID_W;
  localparam int OFF_BST   = OFF_SIZE + RB_W;
  localparam int OFF_T0    = OFF_BST + RB_W;
  localparam int OFF_BMP   = OFF_T0 + 1;

  localparam logic [2:0] MAX_DUR_L = 3'(MAX_DURATION);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CALC  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Everything is reduced mod 2^31, so the low 31 bits of 2^17*A*B + 2*n_id come out exact.
  function automatic logic [30:0] calc_c_init(input logic [SLOT_W-1:0] ns,
                                              input logic [3:0]        sym,
                                              input logic [NID_W-1:0]  nid);
    logic [30:0] a;
    logic [30:0] b;
    logic [30:0] ab;
    a  = 31'(ns) * 31'd14 + 31'(sym) + 31'd1;
    b  = 31'({nid, 1'b1});
    ab = a * b;
    return (ab << 17) + 31'({nid, 1'b0});
  endfunction

  function automatic logic [PN_W-1:0] calc_pn_len(input logic            t0,
                                                  input logic [RB_W-1:0] size,
                                                  input logic [RB_W-1:0] bst);
    logic [PN_W-1:0] span;
    if (t0) begin
      span = PN_W'(size);
    end else begin
      span = PN_W'(size) + PN_W'(bst);
    end
    return span * PN_W'(6);
  endfunction

  function automatic logic [PN_W-1:0] calc_offset(input logic            t0,
                                                  input logic [RB_W-1:0] bst);
    logic [PN_W-1:0] off;
    if (t0) begin
      off = {PN_W{1'b0}};
    end else begin
      off = PN_W'(bst) * PN_W'(6);
    end
    return off;
  endfunction

  state_t             state_q, state_d;
  logic [IN_W-1:0]    cfg_q, cfg_d;
  logic [1:0]         k_q, k_d;
  logic [OUT_W-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               rej_q, rej_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [SLOT_W-1:0]   slot_s;
  logic [3:0]          start_s;
  logic [1:0]          dur_s;
  logic [NID_W-1:0]    nid_s;
  logic [RB_W-1:0]     size_s;
  logic [RB_W-1:0]     bst_s;
  logic                t0_s;
  logic [BITMAP_W-1:0] bmp_s;
  logic [3:0]          sym_s;
  logic                bad_s;
  logic                final_s;
  logic [OUT_W-1:0]    beat_s;

  assign slot_s  = cfg_q[0 +: SLOT_W];
  assign start_s = cfg_q[OFF_START +: 4];
  assign dur_s   = cfg_q[OFF_DUR +: 2];
  assign nid_s   = cfg_q[OFF_NID +: NID_W];
  assign size_s  = cfg_q[OFF_SIZE +: RB_W];
  assign bst_s   = cfg_q[OFF_BST +: RB_W];
  assign t0_s    = cfg_q[OFF_T0];
  assign bmp_s   = cfg_q[OFF_BMP +: BITMAP_W];

  assign sym_s   = start_s + {2'b00, k_q};
  assign final_s = (k_q == (dur_s - 2'd1));
  assign bad_s   = (dur_s == 2'd0) ||
                   ({1'b0, dur_s} > MAX_DUR_L) ||
                   ((5'(start_s) + 5'(dur_s)) > 5'd14) ||
                   (size_s == {RB_W{1'b0}});
  assign beat_s  = {bmp_s, sym_s, calc_offset(t0_s, bst_s),
                    calc_pn_len(t0_s, size_s, bst_s), calc_c_init(slot_s, sym_s, nid_s)};

  // Next-state and output-register logic for the IDLE/CHECK/CALC/OUT sequencer.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    k_d       = k_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    rej_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_cont_config_valid && ready_q) begin
          cfg_d   = s_axis_cont_config_data;
          k_d     = 2'd0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (bad_s) begin
          rej_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        m_data_d  = beat_s;
        m_valid_d = 1'b1;
        m_last_d  = final_s;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (m_axis_cont_config_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (final_s) begin
            state_d = ST_IDLE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cfg_q     <= {IN_W{1'b0}};
      k_q       <= 2'd0;
      m_data_q  <= {OUT_W{1'b0}};
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      rej_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      k_q       <= k_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      rej_q     <= rej_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign s_axis_cont_config_ready = ready_q;
  assign m_axis_cont_config_data  = m_data_q;
  assign m_axis_cont_config_valid = m_valid_q;
  assign m_axis_cont_config_last  = m_last_q;
  assign cfg_reject               = rej_q;
  assign busy                     = busy_q;

endmodule
